mem_stage_ctrl: RTL and testbench

- Memory stage of the 16-bit five-stage pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its flopped outputs.
- Sequences loads and stores to a multi-cycle, stallable data memory. Holds upstream with a stall while a request is outstanding.
- Registers the MEM/WB payload (ALU result, load data, write-back register, control) for the write-back stage.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/dff.sv | 19 +
 rtl/mem_req_fsm.sv | 89 ++++++++
 rtl/mem_stage_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants, the memory-stage state encoding and the mem-op decode.
package pipe_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } mem_state_e;

  // A slot touches data memory only if it is real, enabled, has a direction and no exception.
  function automatic logic is_mem_op(input logic valid, input logic en, input logic rd,
                                     input logic wr, input logic excp);
    return valid & en & (rd | wr) & ~excp;
  endfunction

endpackage

// File: rtl/dff.sv
// Generic enabled flop cell with synchronous active-high clear.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/mem_req_fsm.sv
// Data-memory request sequencer: IDLE -> REQ (held while busy) -> WAIT (until done).
module mem_req_fsm
  import pipe_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int RW = REG_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          is_write,
  input  logic [RW-1:0] wb_reg,
  input  logic          reg_write,
  input  logic          mem_reg,
  input  logic          mem_busy,
  input  logic          mem_done,
  output logic          stall_o,
  output logic          in_idle,
  output logic          done_o,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          req_write,
  output logic [RW-1:0] req_wb_reg,
  output logic          req_reg_write,
  output logic          req_mem_reg
);

  mem_state_e state_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_rd        <= 1'b0;
      mem_wr        <= 1'b0;
      req_write     <= 1'b0;
      req_wb_reg    <= '0;
      req_reg_write <= 1'b0;
      req_mem_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            mem_addr      <= addr;
            mem_wdata     <= wdata;
            mem_rd        <= ~is_write;
            mem_wr        <= is_write;
            req_write     <= is_write;
            req_wb_reg    <= wb_reg;
            req_reg_write <= reg_write;
            req_mem_reg   <= mem_reg;
            state_reg     <= REQ;
          end
        end
        REQ: begin
          // Request lines stay up through busy cycles and drop right after acceptance.
          if (!mem_busy) begin
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (mem_done)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_o = 1'b1;
    case (state_reg)
      IDLE:    stall_o = start;
      WAIT:    stall_o = ~mem_done;
      default: stall_o = 1'b1;
    endcase
  end

  assign in_idle = (state_reg == IDLE);
  assign done_o  = (state_reg == WAIT) & mem_done;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage: sequences loads/stores and registers the MEM/WB payload.
// Optional build macro MEM_ALIGN_CHK_EN turns odd-address memory ops into 1-cycle exceptions.
module mem_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int RW = REG_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [DW-1:0] data_out,
  input  logic [DW-1:0] data_two,
  input  logic [RW-1:0] wb_reg,
  input  logic          Reg_write,
  input  logic          Mem_read,
  input  logic          Mem_write,
  input  logic          Mem_reg,
  input  logic          Mem_en,
  input  logic          Excp,
  output logic          stall_o,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic          mem_busy,
  input  logic          mem_done,
  input  logic [DW-1:0] mem_rdata,
  output logic          valid_o,
  output logic [DW-1:0] wb_alu_o,
  output logic [DW-1:0] wb_ld_o,
  output logic [RW-1:0] wb_reg_o,
  output logic          Reg_write_o,
  output logic          Mem_reg_o,
  output logic          Excp_o
);

  localparam int PW = 2 * DW + RW;

  logic          mem_op, misalign, start;
  logic          in_idle, done_load, pass_load, mwb_load;
  logic          req_write, req_reg_write, req_mem_reg;
  logic [RW-1:0] req_wb_reg;
  logic [DW-1:0] alu_next, ld_next;
  logic [RW-1:0] wb_reg_next;
  logic [2:0]    ctrl_next, ctrl_q;
  logic [PW-1:0] data_q;

  assign mem_op = is_mem_op(valid_i, Mem_en, Mem_read, Mem_write, Excp);

`ifdef MEM_ALIGN_CHK_EN
  assign misalign = mem_op & data_out[0];
`else
  assign misalign = 1'b0;
`endif

  assign start = mem_op & ~misalign;

  mem_req_fsm #(.DW(DW), .RW(RW)) u_fsm (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .addr          (data_out),
    .wdata         (data_two),
    .is_write      (Mem_write),
    .wb_reg        (wb_reg),
    .reg_write     (Reg_write),
    .mem_reg       (Mem_reg),
    .mem_busy      (mem_busy),
    .mem_done      (mem_done),
    .stall_o       (stall_o),
    .in_idle       (in_idle),
    .done_o        (done_load),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .req_write     (req_write),
    .req_wb_reg    (req_wb_reg),
    .req_reg_write (req_reg_write),
    .req_mem_reg   (req_mem_reg)
  );

  // MEM/WB loads either straight from EX/MEM (non-memory slot) or from the finished request.
  assign pass_load = in_idle & ~start;
  assign mwb_load  = pass_load | done_load;

  always_comb begin
    alu_next    = data_out;
    ld_next     = '0;
    wb_reg_next = wb_reg;
    ctrl_next   = {Reg_write & ~misalign, Mem_reg, Excp | misalign};
    if (done_load) begin
      alu_next    = mem_addr;
      ld_next     = req_write ? '0 : mem_rdata;
      wb_reg_next = req_wb_reg;
      ctrl_next   = {req_reg_write, req_mem_reg, 1'b0};
    end
  end

  dff #(.W(1)) u_valid (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (mwb_load & (done_load | valid_i)),
    .q   (valid_o)
  );

  dff #(.W(PW)) u_data (
    .clk (clk),
    .rst (rst),
    .en  (mwb_load),
    .d   ({alu_next, ld_next, wb_reg_next}),
    .q   (data_q)
  );

  assign {wb_alu_o, wb_ld_o, wb_reg_o} = data_q;

  for (genvar gi = 0; gi < 3; gi++) begin : g_ctrl
    dff #(.W(1)) u_ctrl (
      .clk (clk),
      .rst (rst),
      .en  (mwb_load),
      .d   (ctrl_next[gi]),
      .q   (ctrl_q[gi])
    );
  end

  assign {Reg_write_o, Mem_reg_o, Excp_o} = ctrl_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed + random bench for mem_stage_ctrl with a transaction-level memory and result model.
module tb_mem_stage_ctrl;

`ifdef MEM_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [15:0] data_out, data_two;
  logic [2:0]  wb_reg;
  logic        Reg_write, Mem_read, Mem_write, Mem_reg, Mem_en, Excp;
  logic        stall_o;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_rd, mem_wr;
  logic        mem_busy, mem_done;
  logic [15:0] mem_rdata;
  logic        valid_o;
  logic [15:0] wb_alu_o, wb_ld_o;
  logic [2:0]  wb_reg_o;
  logic        Reg_write_o, Mem_reg_o, Excp_o;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_out(data_out), .data_two(data_two),
    .wb_reg(wb_reg), .Reg_write(Reg_write), .Mem_read(Mem_read), .Mem_write(Mem_write),
    .Mem_reg(Mem_reg), .Mem_en(Mem_en), .Excp(Excp), .stall_o(stall_o),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata), .valid_o(valid_o),
    .wb_alu_o(wb_alu_o), .wb_ld_o(wb_ld_o), .wb_reg_o(wb_reg_o),
    .Reg_write_o(Reg_write_o), .Mem_reg_o(Mem_reg_o), .Excp_o(Excp_o)
  );

  typedef struct {
    logic v, en, rd, wr, rw, mr, ex;
    logic [15:0] a, d;
    logic [2:0] r;
  } instr_t;

  typedef struct {
    logic wr;
    logic [15:0] a, d;
  } acc_t;

  acc_t        acc_q[$];
  logic [15:0] phys_mem [256];
  logic [15:0] ref_mem  [256];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          busy_left, busy_cnt, done_left, fix_busy, fix_k, last_busy, last_k;
  logic [15:0] done_data;
  logic        e_v, e_rw, e_mr, e_ex;
  logic [15:0] e_alu, e_ld;
  logic [2:0]  e_reg;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply(input instr_t i);
    valid_i = i.v; Mem_en = i.en; Mem_read = i.rd; Mem_write = i.wr;
    Reg_write = i.rw; Mem_reg = i.mr; Excp = i.ex;
    data_out = i.a; data_two = i.d; wb_reg = i.r;
  endtask

  function automatic instr_t mk(input logic v, input logic en, input logic rd, input logic wr,
                                input logic [15:0] a, input logic [15:0] d, input logic [2:0] r);
    instr_t i;
    i.v = v; i.en = en; i.rd = rd; i.wr = wr; i.a = a; i.d = d; i.r = r;
    i.rw = rd & ~wr | ~en; i.mr = rd & ~wr; i.ex = 1'b0;
    return i;
  endfunction

  // Memory responder: busy/done behaviour plus acceptance checks against the expected access order.
  task automatic mem_drive();
    acc_t e;
    mem_done  = 1'b0;
    mem_busy  = 1'b0;
    mem_rdata = 16'($urandom);
    if (done_left == 0) begin
      mem_done  = 1'b1;
      mem_rdata = done_data;
      done_left = -1;
    end else if (done_left > 0) begin
      done_left--;
    end
    if (mem_rd || mem_wr) begin
      chk1("access_pending", acc_q.size() != 0, 1'b1);
      if (acc_q.size() != 0) begin
        e = acc_q[0];
        chk16("req_dir", 16'({mem_wr, mem_rd}), 16'({e.wr, ~e.wr}));
        chk16("req_addr", mem_addr, e.a);
        if (e.wr) chk16("req_wdata", mem_wdata, e.d);
        if (busy_left > 0) begin
          mem_busy = 1'b1;
          busy_left--;
          busy_cnt++;
        end else begin
          void'(acc_q.pop_front());
          last_busy = busy_cnt;
          busy_cnt  = 0;
          last_k    = (fix_k >= 0) ? fix_k : int'($urandom_range(2, 0));
          done_left = last_k;
          if (e.wr) begin
            phys_mem[e.a[7:0]] = e.d;
            done_data = 16'($urandom);
          end else begin
            done_data = phys_mem[e.a[7:0]];
          end
          busy_left = (fix_busy >= 0) ? fix_busy : int'($urandom_range(3, 0));
        end
      end
    end else begin
      mem_busy = 1'($urandom_range(1, 0));
    end
  endtask

  // Presents one instruction, holds it while stalled, and checks the single MEM/WB result.
  task automatic run_instr(input instr_t ins);
    logic memop, mis, go, consumed, first;
    int   stalls, reqs, cyc;
    acc_t t;
    apply(ins);
    memop = ins.v & ins.en & (ins.rd | ins.wr) & ~ins.ex;
    mis   = ALIGN & memop & ins.a[0];
    go    = memop & ~mis;
    e_v = ins.v; e_alu = ins.a; e_reg = ins.r; e_mr = ins.mr;
    e_ex = ins.ex | mis; e_rw = ins.rw & ~mis; e_ld = 16'h0000;
    if (go) begin
      t.wr = ins.wr; t.a = ins.a; t.d = ins.d;
      acc_q.push_back(t);
      if (ins.wr) ref_mem[ins.a[7:0]] = ins.d;
      else        e_ld = ref_mem[ins.a[7:0]];
    end
    stalls = 0; reqs = 0; cyc = 0; consumed = 1'b0; first = 1'b1;
    while (!consumed && cyc < 64) begin
      mem_drive();
      #1;
      if (first) chk1("stall_first", stall_o, go);
      first = 1'b0;
      if (stall_o) stalls++;
      if (mem_rd || mem_wr) reqs++;
      consumed = ~stall_o;
      @(negedge clk);
      if (consumed) begin
        chk1("valid_o", valid_o, e_v);
        if (e_v) begin
          chk16("wb_alu", wb_alu_o, e_alu);
          chk16("wb_ld", wb_ld_o, e_ld);
          chk16("wb_reg", 16'(wb_reg_o), 16'(e_reg));
          chk1("Reg_write_o", Reg_write_o, e_rw);
          chk1("Mem_reg_o", Mem_reg_o, e_mr);
          chk1("Excp_o", Excp_o, e_ex);
        end
      end else begin
        chk1("bubble", valid_o, 1'b0);
      end
      cyc++;
    end
    chk1("no_timeout", consumed, 1'b1);
    if (go) begin
      chki("stall_cycles", stalls, 2 + last_busy + last_k);
      chki("req_cycles", reqs, last_busy + 1);
    end else begin
      chki("no_req", reqs, 0);
    end
    $display("txn v=%0b en=%0b rd=%0b wr=%0b ex=%0b a=%h d=%h -> stalls=%0d reqs=%0d",
             ins.v, ins.en, ins.rd, ins.wr, ins.ex, ins.a, ins.d, stalls, reqs);
  endtask

  initial begin
    instr_t ins;
    for (int i = 0; i < 256; i++) begin
      phys_mem[i] = 16'($urandom);
      ref_mem[i]  = phys_mem[i];
    end
    busy_left = 0; busy_cnt = 0; done_left = -1; fix_busy = 0; fix_k = 0;
    last_busy = 0; last_k = 0; done_data = '0;
    rst = 1'b1; mem_busy = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0));
    repeat (2) @(negedge clk);
    chk1("rst_valid_o", valid_o, 1'b0);
    chk1("rst_stall", stall_o, 1'b0);
    chk1("rst_mem_rd", mem_rd, 1'b0);
    chk1("rst_mem_wr", mem_wr, 1'b0);
    chk16("rst_wb_alu", wb_alu_o, 16'h0000);
    chk16("rst_wb_ld", wb_ld_o, 16'h0000);
    chk16("rst_mem_addr", mem_addr, 16'h0000);
    chk1("rst_excp", Excp_o, 1'b0);
    rst = 1'b0;

    // ALU op, then a load with no busy, then a store held busy for 3 cycles
    run_instr(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h5555, 3'd3));
    phys_mem[8'h40] = 16'hBEEF;
    ref_mem[8'h40]  = 16'hBEEF;
    run_instr(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 3'd5));
    busy_left = 3;
    run_instr(mk(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h00FF, 3'd1));
    // Both direction bits set: must behave as a store
    run_instr(mk(1'b1, 1'b1, 1'b1, 1'b1, 16'h0012, 16'hA5A5, 3'd2));
    run_instr(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 3'd6));
    run_instr(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0004, 16'h0000, 3'd7));
    ins = mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 3'd4);
    ins.ex = 1'b1;
    run_instr(ins);

    // Reset while waiting for done; the late done must be ignored
    apply(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 3'd2));
    mem_busy = 1'b0; mem_done = 1'b0;
    @(negedge clk);
    chk1("rstw_req_rd", mem_rd, 1'b1);
    @(negedge clk);
    chk1("rstw_rd_low", mem_rd, 1'b0);
    #1 chk1("rstw_stall", stall_o, 1'b1);
    rst = 1'b1;
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("rstw_idle_stall", stall_o, 1'b0);
    chk1("rstw_valid_o", valid_o, 1'b0);
    chk1("rstw_mem_rd", mem_rd, 1'b0);
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    #1 chk1("late_done_stall", stall_o, 1'b0);
    @(negedge clk);
    chk1("late_done_valid", valid_o, 1'b0);
    mem_done = 1'b0;
    $display("txn reset-in-WAIT sequence complete");
    busy_left = 0; busy_cnt = 0; done_left = -1;

    run_instr(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0777, 16'h0000, 3'd1));
    run_instr(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h0000, 3'd3));

    fix_busy = -1; fix_k = -1;
    for (int n = 0; n < 200; n++) begin
      ins.v  = ($urandom_range(7, 0) != 0);
      ins.en = 1'($urandom_range(1, 0));
      ins.rd = 1'($urandom_range(1, 0));
      ins.wr = 1'($urandom_range(1, 0));
      ins.rw = 1'($urandom_range(1, 0));
      ins.mr = 1'($urandom_range(1, 0));
      ins.ex = ($urandom_range(7, 0) == 0);
      ins.a  = {8'h00, 8'($urandom)};
      if ($urandom_range(5, 0) != 0) ins.a[0] = 1'b0;
      ins.d  = 16'($urandom);
      ins.r  = 3'($urandom);
      run_instr(ins);
    end

    run_instr(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0));
    chki("acc_q_drained", acc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
